// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access controller.
//   state_t        : controller FSM states
//   ROM_BASE       : start of the read-only region
//   RAM_BASE       : start of the read/write region
//   RAM_LIMIT      : first illegal address above RAM
//   addr_in_rom    : address decodes to the ROM region
//   access_illegal : access must be rejected with an error response
package mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_HOLD   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    localparam logic [15:0] ROM_BASE  = 16'h0000;
    localparam logic [15:0] RAM_BASE  = 16'h2000;
    localparam logic [15:0] RAM_LIMIT = 16'h4000;

    // ROM is the 8 KiB window whose top three address bits match ROM_BASE.
    function automatic logic addr_in_rom(input logic [15:0] addr);
        return (addr[15:13] == ROM_BASE[15:13]);
    endfunction

    // Out-of-map addresses are never legal; ROM additionally rejects stores.
    function automatic logic access_illegal(input logic write, input logic [15:0] addr);
        return (addr >= RAM_LIMIT) || (write && (addr < RAM_BASE));
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable 4-bit down-counter that times the ACCESS phase.
//   clk, rst_n  : clock and asynchronous active-low reset
//   load        : load load_value on the next edge (has priority)
//   load_value  : value to load
//   dec         : decrement by one, saturating at zero
//   zero        : counter currently holds zero
module mem_wait_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count_r;

    // Counter register: load, saturating decrement, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 4'd0;
        end else if (load) begin
            count_r <= load_value;
        end else if (dec && (count_r != 4'd0)) begin
            count_r <= count_r - 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == 4'd0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller between the pipeline MEM stage and the memory
// I/O mapper. Each accepted request walks SETUP -> ACCESS(W cycles) -> HOLD,
// or goes straight to a one-cycle ERR for out-of-map accesses or ROM stores.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_write/addr/wdata: request fields, latched on acceptance
//   resp_valid/resp_err : one-cycle completion pulse and its error qualifier
//   resp_rdata          : registered load data
//   busy                : controller not idle
//   read_memory         : load strobe during ACCESS
//   write_memory        : store strobe during ACCESS
//   mem_address         : address to the mapper (0 when no access is active)
//   internal_data_bus   : shared bidirectional data bus
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ROM_WAIT = 2,
    parameter int RAM_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [7:0]  resp_rdata,
    output logic        busy,
    output logic        read_memory,
    output logic        write_memory,
    output logic [15:0] mem_address,
    inout  wire  [7:0]  internal_data_bus
);

    // The counter starts at W-1 so that it reaches zero in the last ACCESS cycle.
    localparam logic [3:0] ROM_LOAD = 4'(ROM_WAIT - 1);
    localparam logic [3:0] RAM_LOAD = 4'(RAM_WAIT - 1);

    state_t      state_r;
    state_t      next_state_s;
    logic        write_r;
    logic [15:0] addr_r;
    logic [7:0]  wdata_r;
    logic [7:0]  rdata_r;
    logic        accept_s;
    logic        cnt_zero_s;
    logic        bus_en_s;

    assign accept_s = req_valid && (state_r == ST_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    next_state_s = access_illegal(req_write, req_addr) ? ST_ERR : ST_SETUP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SETUP:  next_state_s = ST_ACCESS;
            ST_ACCESS: begin
                if (cnt_zero_s) begin
                    next_state_s = ST_HOLD;
                end else begin
                    next_state_s = ST_ACCESS;
                end
            end
            ST_HOLD:   next_state_s = ST_IDLE;
            ST_ERR:    next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Request latch: captured once on acceptance, ignored until back in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_r <= 1'b0;
            addr_r  <= 16'h0000;
            wdata_r <= 8'h00;
        end else if (accept_s) begin
            write_r <= req_write;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
        end else begin
            write_r <= write_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Loaded during SETUP, counts down through ACCESS.
    mem_wait_counter u_wait_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (state_r == ST_SETUP),
        .load_value (addr_in_rom(addr_r) ? ROM_LOAD : RAM_LOAD),
        .dec        (state_r == ST_ACCESS),
        .zero       (cnt_zero_s)
    );

    // Load data capture on the edge that ends the final ACCESS cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 8'h00;
        end else if ((state_r == ST_ACCESS) && cnt_zero_s && !write_r) begin
            rdata_r <= internal_data_bus;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    // Output decode from the state register and latched request only.
    always_comb begin
        req_ready    = 1'b0;
        busy         = 1'b1;
        resp_valid   = 1'b0;
        resp_err     = 1'b0;
        read_memory  = 1'b0;
        write_memory = 1'b0;
        mem_address  = 16'h0000;
        bus_en_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_SETUP: begin
                mem_address = addr_r;
            end
            ST_ACCESS: begin
                mem_address  = addr_r;
                read_memory  = !write_r;
                write_memory = write_r;
                bus_en_s     = write_r;
            end
            ST_HOLD: begin
                mem_address = addr_r;
                resp_valid  = 1'b1;
            end
            ST_ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign resp_rdata        = rdata_r;
    assign internal_data_bus = bus_en_s ? wdata_r : 8'hzz;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam int ROM_WAIT = 2;
    localparam int RAM_WAIT = 1;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [7:0]  resp_rdata;
    logic        busy;
    logic        read_memory;
    logic        write_memory;
    logic [15:0] mem_address;
    wire  [7:0]  internal_data_bus;

    mem_access_ctrl #(.ROM_WAIT(ROM_WAIT), .RAM_WAIT(RAM_WAIT)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .resp_valid        (resp_valid),
        .resp_err          (resp_err),
        .resp_rdata        (resp_rdata),
        .busy              (busy),
        .read_memory       (read_memory),
        .write_memory      (write_memory),
        .mem_address       (mem_address),
        .internal_data_bus (internal_data_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behind the mapper: drives the bus on loads, captures stores.
    logic [7:0]  phys_mem [0:16383];
    logic        pre_we;
    logic [13:0] pre_addr;
    logic [7:0]  pre_data;

    assign internal_data_bus = read_memory ? phys_mem[mem_address[13:0]] : 8'hzz;

    always @(posedge clk) begin
        if (write_memory) phys_mem[mem_address[13:0]] <= internal_data_bus;
        if (pre_we) phys_mem[pre_addr] <= pre_data;
    end

    // Reference model state.
    logic [7:0] ref_mem [0:16383];
    logic [7:0] ref_rdata;

    int tests;
    int fails;
    int strobe_viol;

    always @(negedge clk) begin
        if ((read_memory && write_memory) || (write_memory && (mem_address < 16'h2000)))
            strobe_viol++;
    end

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  preload;
        logic        exp_err;
        int          exp_lat;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [10];

    // Per-operation observations.
    int         op_gap, op_lat, op_rd, op_wr, op_addr_bad, op_ready_bad;
    logic       op_err, op_timeout;
    logic [7:0] op_rdata, op_bus;

    function automatic logic model_err(input logic wr, input logic [15:0] a);
        return (a >= 16'h4000) || (wr && (a < 16'h2000));
    endfunction

    function automatic int model_wait(input logic [15:0] a);
        return (a < 16'h2000) ? ROM_WAIT : RAM_WAIT;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] v);
        pre_we   = 1'b1;
        pre_addr = a[13:0];
        pre_data = v;
        @(posedge clk);
        #1 pre_we = 1'b0;
        ref_mem[a[13:0]] = v;
        @(negedge clk);
    endtask

    // Issue one request from a negedge and follow it to its response.
    task automatic run_op(input logic wr, input logic [15:0] a, input logic [7:0] d,
                          input bit keep_valid, input logic [15:0] exp_addr);
        int  c;
        bit  done;
        op_gap = 0; op_rd = 0; op_wr = 0; op_addr_bad = 0; op_ready_bad = 0;
        op_lat = 0; op_err = 1'b0; op_bus = 8'h00; op_rdata = 8'h00; op_timeout = 1'b0;
        while (!req_ready && op_gap < 50) begin
            @(negedge clk);
            op_gap++;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        // Scramble the request fields: the controller must have latched them.
        req_addr  = 16'($urandom);
        req_write = 1'($urandom);
        req_wdata = 8'($urandom);
        if (!keep_valid) req_valid = 1'b0;
        c = 1;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (read_memory) op_rd++;
            if (write_memory) begin
                op_wr++;
                op_bus = internal_data_bus;
            end
            if (mem_address != exp_addr) op_addr_bad++;
            if (req_ready || !busy) op_ready_bad++;
            if (resp_valid) begin
                op_lat   = c;
                op_err   = resp_err;
                op_rdata = resp_rdata;
                done     = 1'b1;
            end else if (c >= 40) begin
                op_timeout = 1'b1;
                done       = 1'b1;
            end
            c++;
        end
    endtask

    // Compare one operation against the expected outcome, then advance the model.
    task automatic judge(input string tag, input logic wr, input logic [15:0] a,
                         input logic [7:0] d, input logic exp_err, input int exp_lat,
                         input logic [7:0] exp_rdata);
        int strobes;
        strobes = exp_err ? 0 : exp_lat - 2;
        chk({tag, " timeout"}, int'(op_timeout), 0);
        chk({tag, " latency"}, op_lat, exp_lat);
        chk({tag, " resp_err"}, int'(op_err), int'(exp_err));
        chk({tag, " read strobes"}, op_rd, wr ? 0 : strobes);
        chk({tag, " write strobes"}, op_wr, wr ? strobes : 0);
        chk({tag, " resp_rdata"}, int'(op_rdata), int'(exp_rdata));
        chk({tag, " mem_address"}, op_addr_bad, 0);
        chk({tag, " ready/busy"}, op_ready_bad, 0);
        if (wr && !exp_err) begin
            chk({tag, " bus data"}, int'(op_bus), int'(d));
            chk({tag, " memory"}, int'(phys_mem[a[13:0]]), int'(d));
            ref_mem[a[13:0]] = d;
        end
        ref_rdata = exp_rdata;
    endtask

    initial begin
        logic        wr;
        logic [15:0] a;
        logic [7:0]  d;
        logic        e;
        int          lat;
        logic [7:0]  exp_rd;
        int          resp_seen;

        tests = 0; fails = 0; strobe_viol = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 16'h0000; req_wdata = 8'h00;
        pre_we = 1'b0; pre_addr = 14'd0; pre_data = 8'h00;
        ref_rdata = 8'h00;

        vecs[0] = '{1'b0, 16'h2005, 8'h00, 8'hA5, 1'b0, 3, 8'hA5};
        vecs[1] = '{1'b0, 16'h0010, 8'h00, 8'h3C, 1'b0, 4, 8'h3C};
        vecs[2] = '{1'b1, 16'h3FFF, 8'h5A, 8'h00, 1'b0, 3, 8'h3C};
        vecs[3] = '{1'b1, 16'h1000, 8'hEE, 8'h00, 1'b1, 1, 8'h3C};
        vecs[4] = '{1'b0, 16'h4000, 8'h00, 8'h00, 1'b1, 1, 8'h3C};
        vecs[5] = '{1'b0, 16'h3FFF, 8'h00, 8'h00, 1'b0, 3, 8'h5A};
        vecs[6] = '{1'b0, 16'h1FFF, 8'h00, 8'h77, 1'b0, 4, 8'h77};
        vecs[7] = '{1'b0, 16'hFFFF, 8'h00, 8'h00, 1'b1, 1, 8'h77};
        vecs[8] = '{1'b1, 16'h2000, 8'hC3, 8'h00, 1'b0, 3, 8'h77};
        vecs[9] = '{1'b1, 16'h1FFF, 8'h99, 8'h00, 1'b1, 1, 8'h77};

        // Reset state.
        #3;
        chk("reset busy", int'(busy), 0);
        chk("reset resp_valid", int'(resp_valid), 0);
        chk("reset resp_err", int'(resp_err), 0);
        chk("reset resp_rdata", int'(resp_rdata), 0);
        chk("reset mem_address", int'(mem_address), 0);
        chk("reset strobes", int'({read_memory, write_memory}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle ready", int'(req_ready), 1);

        // Directed table (vector 5 reads back what vector 2 stored).
        for (int i = 0; i < 10; i++) begin
            if (!vecs[i].wr && !vecs[i].exp_err && i != 5)
                preload(vecs[i].addr, vecs[i].preload);
            run_op(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0,
                   vecs[i].exp_err ? 16'h0000 : vecs[i].addr);
            judge($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                  vecs[i].exp_err, vecs[i].exp_lat, vecs[i].exp_rdata);
        end

        // Reset in the middle of a store's ACCESS cycle.
        preload(16'h2100, 8'h11);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h2100; req_wdata = 8'h99;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort write strobe before", int'(write_memory), 1);
        rst_n = 1'b0;
        #1;
        chk("abort strobes", int'({read_memory, write_memory}), 0);
        chk("abort resp_valid", int'(resp_valid), 0);
        chk("abort mem_address", int'(mem_address), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort resp_rdata", int'(resp_rdata), 0);
        resp_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
        end
        rst_n = 1'b1;
        #1 chk("abort ready after release", int'(req_ready), 1);
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
        end
        chk("abort no response", resp_seen, 0);
        chk("abort memory untouched", int'(phys_mem[14'h2100]), 8'h11);
        ref_rdata = 8'h00;

        // Back-to-back loads with req_valid held high.
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: a = 16'h2010;
                1: a = 16'h0020;
                2: a = 16'h3000;
                default: a = 16'h1234;
            endcase
            preload(a, 8'(8'h40 + i * 8'h13));
        end
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: a = 16'h2010;
                1: a = 16'h0020;
                2: a = 16'h3000;
                default: a = 16'h1234;
            endcase
            run_op(1'b0, a, 8'h00, 1'b1, a);
            if (i == 3) req_valid = 1'b0;
            if (i > 0) chk($sformatf("b2b%0d gap", i), op_gap, 1);
            judge($sformatf("b2b%0d", i), 1'b0, a, 8'h00, 1'b0,
                  2 + model_wait(a), ref_mem[a[13:0]]);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: a = 16'($urandom_range(0, 16'h1FFF));
                1: a = 16'($urandom_range(16'h2000, 16'h3FFF));
                default: a = 16'($urandom_range(16'h4000, 16'hFFFF));
            endcase
            wr = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            e  = model_err(wr, a);
            if (!wr && !e) preload(a, 8'($urandom));
            lat    = e ? 1 : 2 + model_wait(a);
            exp_rd = (e || wr) ? ref_rdata : ref_mem[a[13:0]];
            run_op(wr, a, d, 1'b0, e ? 16'h0000 : a);
            judge($sformatf("rand%0d", i), wr, a, d, e, lat, exp_rd);
        end

        @(negedge clk);
        chk("strobe rule violations", strobe_viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
